// File: rtl/regfile_exec_unit.sv
// Parametrised register file with a host read/write port and a four-state
// (IDLE/FETCH/EXEC/WB) ALU sequencer that writes results back into the file.
module regfile_exec_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] address,
    input  logic              write_en,
    input  logic              read_en,
    output logic [DATA_W-1:0] data_out,
    input  logic              op_start,
    input  logic [1:0]        op_sel,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    output logic              busy,
    output logic              done,
    output logic [3:0]        flag
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ADC, OP_AND} op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W:0]   res_q, res_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [3:0]        flag_q, flag_d;

    logic addr_ok, src_a_ok, src_b_ok, dst_ok;
    logic ovf, cout, a_msb, b_msb, r_msb;

    // Non-power-of-two depths leave part of the address space unbacked.
    assign addr_ok  = 32'(address) < DEPTH;
    assign src_a_ok = 32'(src_a_q) < DEPTH;
    assign src_b_ok = 32'(src_b_q) < DEPTH;
    assign dst_ok   = 32'(dst_q)   < DEPTH;

    assign a_msb = a_q[DATA_W-1];
    assign b_msb = b_q[DATA_W-1];
    assign r_msb = res_q[DATA_W-1];

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        dst_d      = dst_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        mem_d      = mem_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        flag_d     = flag_q;
        ovf        = 1'b0;
        cout       = 1'b0;

        // Reads use the pre-edge contents, so a same-edge write returns the old value.
        if (read_en) data_out_d = addr_ok ? mem_q[address] : '0;
        if (write_en && !busy_q && addr_ok) mem_d[address] = data_in;

        unique case (op_q)
            OP_ADD, OP_ADC: begin
                ovf  = (a_msb == b_msb) && (r_msb != a_msb);
                cout = res_q[DATA_W];
            end
            OP_SUB: begin
                ovf  = (a_msb != b_msb) && (r_msb != a_msb);
                cout = res_q[DATA_W];
            end
            OP_AND: begin
                ovf  = 1'b0;
                cout = 1'b0;
            end
        endcase

        unique case (state_q)
            IDLE: if (op_start) begin
                op_d    = op_e'(op_sel);
                src_a_d = src_a;
                src_b_d = src_b;
                dst_d   = dst;
                busy_d  = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                a_d     = src_a_ok ? mem_q[src_a_q] : '0;
                b_d     = src_b_ok ? mem_q[src_b_q] : '0;
                state_d = EXEC;
            end
            EXEC: begin
                unique case (op_q)
                    OP_ADD: res_d = {1'b0, a_q} + {1'b0, b_q};
                    OP_SUB: res_d = {1'b0, a_q} - {1'b0, b_q};
                    OP_ADC: res_d = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, flag_q[0]};
                    OP_AND: res_d = {1'b0, a_q & b_q};
                endcase
                state_d = WB;
            end
            WB: begin
                if (dst_ok) mem_d[dst_q] = res_q[DATA_W-1:0];
                flag_d  = {ovf, r_msb, (res_q[DATA_W-1:0] == '0), cout};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= OP_ADD;
            src_a_q    <= '0;
            src_b_q    <= '0;
            dst_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            // NOTE: the register array is cleared on reset because software relies on zeroed registers.
            mem_q      <= '{default: '0};
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            flag_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            dst_q      <= dst_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            mem_q      <= mem_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            flag_q     <= flag_d;
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign flag     = flag_q;

endmodule

// File: tb/tb_regfile_exec_unit.sv
// Scoreboard bench for regfile_exec_unit: stimulus pushes expected flags and
// read data into queues, a negedge monitor pops and compares them.
module tb_regfile_exec_unit;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [ADDR_W-1:0] address = '0;
    logic              write_en = 1'b0;
    logic              read_en = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              op_start = 1'b0;
    logic [1:0]        op_sel = 2'b00;
    logic [ADDR_W-1:0] src_a = '0, src_b = '0, dst = '0;
    logic              busy, done;
    logic [3:0]        flag;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, AND = 2'b11;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic rd_vld = 1'b0;
    logic [3:0]        flag_q_exp [$];
    logic [DATA_W-1:0] rd_q_exp [$];

    regfile_exec_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .address(address),
        .write_en(write_en), .read_en(read_en), .data_out(data_out),
        .op_start(op_start), .op_sel(op_sel), .src_a(src_a), .src_b(src_b),
        .dst(dst), .busy(busy), .done(done), .flag(flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_vld <= read_en && rst;

    // Monitor: every done pulse and every completed host read pops one expectation.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (flag_q_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 with flag 0x%0h, expected no operation", flag);
            end else begin
                check("flag", 32'(flag), 32'(flag_q_exp.pop_front()));
            end
        end
        if (rd_vld) begin
            if (rd_q_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_read: got data 0x%0h, expected no read", data_out);
            end else begin
                check("read_data", 32'(data_out), 32'(rd_q_exp.pop_front()));
            end
        end
    end

    // All tasks start and end just after a falling edge.
    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        write_en = 1'b1; address = a; data_in = d;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic host_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        rd_q_exp.push_back(exp);
        read_en = 1'b1; address = a;
        @(negedge clk);
        read_en = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'h0);
        check({tag, "_flag"}, 32'(flag), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [ADDR_W-1:0] sa, sb, d,
                          input logic [3:0] exp_flag, input logic [DATA_W-1:0] exp_val);
        int c0;
        c0 = done_cnt;
        flag_q_exp.push_back(exp_flag);
        op_start = 1'b1; op_sel = op; src_a = sa; src_b = sb; dst = d;
        @(negedge clk);                       // E0 sampled
        op_start = 1'b0; write_en = 1'b0;
        check("busy_after_e0", 32'(busy), 32'h1);
        @(negedge clk);
        check("busy_after_e1", 32'(busy), 32'h1);
        check("no_done_e1", 32'(done), 32'h0);
        @(negedge clk);
        check("busy_after_e2", 32'(busy), 32'h1);
        check("no_done_e2", 32'(done), 32'h0);
        @(negedge clk);                       // E3: write-back, done seen by monitor
        check("busy_after_e3", 32'(busy), 32'h0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'h0);
        check("done_count", 32'(done_cnt - c0), 32'h1);
        host_read(d, exp_val);
    endtask

    initial begin
        int c0;

        // Power-on reset
        apply_reset();
        check_idle_outputs("por");

        // Reset clears earlier writes
        host_write(5'd3, 8'hAA);
        host_write(5'd10, 8'h12);
        host_read(5'd3, 8'hAA);
        apply_reset();
        check_idle_outputs("rst");
        for (int i = 0; i < DEPTH; i++) host_read(ADDR_W'(i), 8'h00);

        // ADD with signed overflow and carry
        host_write(5'd4, 8'd141);
        host_write(5'd5, 8'd208);
        run_op(ADD, 5'd4, 5'd5, 5'd2, 4'b1001, 8'd93);

        // Carry chain: ADD producing carry, then ADC consuming it
        host_write(5'd0, 8'hFF);
        host_write(5'd1, 8'h01);
        run_op(ADD, 5'd0, 5'd1, 5'd2, 4'b0011, 8'h00);
        host_write(5'd6, 8'h00);
        host_write(5'd7, 8'h00);
        run_op(ADC, 5'd6, 5'd7, 5'd3, 4'b0000, 8'h01);

        // SUB with borrow, then AND
        host_write(5'd8, 8'd32);
        host_write(5'd7, 8'd208);
        run_op(SUB, 5'd8, 5'd7, 5'd9, 4'b0001, 8'd80);
        run_op(AND, 5'd7, 5'd7, 5'd10, 4'b0100, 8'd208);

        // Same-edge write and read returns the old value
        host_write(5'd11, 8'h33);
        rd_q_exp.push_back(8'h33);
        write_en = 1'b1; read_en = 1'b1; address = 5'd11; data_in = 8'h44;
        @(negedge clk);
        write_en = 1'b0; read_en = 1'b0;
        host_read(5'd11, 8'h44);

        // Write with op_start in IDLE lands before FETCH; src_a=src_b=dst
        host_write(5'd12, 8'd1);
        write_en = 1'b1; address = 5'd12; data_in = 8'd5;
        run_op(ADD, 5'd12, 5'd12, 5'd12, 4'b0000, 8'd10);

        // Busy protection: host write and op_start held through the whole op
        c0 = done_cnt;
        flag_q_exp.push_back(4'b1001);
        op_start = 1'b1; op_sel = ADD; src_a = 5'd4; src_b = 5'd5; dst = 5'd2;
        @(negedge clk);
        op_sel = AND; src_a = 5'd0; src_b = 5'd0; dst = 5'd2;
        write_en = 1'b1; address = 5'd2; data_in = 8'h55;
        repeat (3) @(negedge clk);
        op_start = 1'b0; write_en = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_prot_done_count", 32'(done_cnt - c0), 32'h1);
        check("busy_prot_idle", 32'(busy), 32'h0);
        host_read(5'd2, 8'd93);

        // Reset asserted while the op is in EXEC
        c0 = done_cnt;
        op_start = 1'b1; op_sel = ADD; src_a = 5'd4; src_b = 5'd5; dst = 5'd2;
        @(negedge clk);                       // E0
        op_start = 1'b0;
        @(negedge clk);                       // E1, now in EXEC
        rst = 1'b0;
        @(negedge clk);                       // E2 sampled reset
        rst = 1'b1;
        check("midop_busy", 32'(busy), 32'h0);
        repeat (4) @(negedge clk);
        check("midop_no_done", 32'(done_cnt - c0), 32'h0);
        check_idle_outputs("midop");
        for (int i = 0; i < DEPTH; i++) host_read(ADDR_W'(i), 8'h00);

        // Fresh op after reset: positive overflow into negative
        host_write(5'd0, 8'h7F);
        host_write(5'd1, 8'h01);
        run_op(ADD, 5'd0, 5'd1, 5'd20, 4'b1100, 8'h80);

        repeat (3) @(negedge clk);
        check("flag_queue_drained", 32'(flag_q_exp.size()), 32'h0);
        check("read_queue_drained", 32'(rd_q_exp.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_exec_unit.md
# regfile_exec_unit

Parametrised register file with an integrated multi-cycle ALU sequencer for the execution unit. It generalises the 8-bit register memory to configurable width and depth. It adds a clocked FETCH/EXEC/WB state machine with start/busy/done handshake, three-operand addressing (src_a, src_b, dst) and carry-chained arithmetic for multi-word operations. A host port for loading and inspecting registers sits alongside the ALU port.

## Interface
- DATA_W, 8, register and ALU datapath width in bits (≥4)
- DEPTH, 32, number of registers; ADDR_W = clog2(DEPTH), derived, not overridable
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk
- data_in  in  DATA_W  host write data
- address  in  ADDR_W  host read/write address
- write_en  in  1  host write strobe
- read_en  in  1  host read strobe
- data_out  out  DATA_W  registered host read data
- op_start  in  1  start ALU operation; sampled only in IDLE
- op_sel  in  2  00 ADD, 01 SUB (A−B), 10 ADC (A+B+C), 11 AND
- src_a, src_b, dst  in  ADDR_W each  operand and destination register addresses
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse on write-back
- flag  out  4  {V,N,Z,C}

## Operation
- Reset (rst=0 at an edge):
  - all registers, data_out, flag, busy and done cleared to 0; state to IDLE.
  - Reset overrides every other input, including in mid-operation. No done pulse, no write-back.
- Host write: when write_en=1 at an edge and busy=0, reg[address] <= data_in. Writes are ignored while busy=1.
- Host read: when read_en=1 at an edge, data_out <= reg[address]. Reads are permitted while busy. data_out holds when read_en=0.
- Out-of-range address (≥DEPTH, any port):
  - writes are dropped;
  - reads return 0;
  - an op whose dst is out of range completes and updates flag, with no register written.
- Host write and read to the same address at the same edge: data_out returns the old value.
- FSM states: IDLE → FETCH → EXEC → WB → IDLE.
  - IDLE: op_start=1 latches op_sel, src_a, src_b and dst; go to FETCH. busy is set at this edge.
  - FETCH: latch A=reg[src_a], B=reg[src_b].
  - EXEC: compute a registered (DATA_W+1)-bit result.
  - WB: reg[dst] <= result[DATA_W−1:0]; flag updated; done=1; busy=0; return to IDLE.
- op_start is ignored while busy. src_a=src_b=dst is allowed; operands are the pre-write values.
- Host write plus op_start at the same edge in IDLE: the write lands, and FETCH sees the new value.
- Arithmetic (all modulo 2^DATA_W):
  - ADD: C = carry out.
  - SUB: C = borrow (1 when A<B unsigned).
  - ADC: carry-in is flag C as held at EXEC.
  - AND: C=0 and V=0.
- Flags:
  - Z: result = 0.
  - N: result MSB.
  - V: two's-complement overflow for ADD/ADC/SUB.
- flag changes only at WB or reset.

## Timing
- Host read latency: 1 cycle (data_out valid after the edge sampling read_en).
- Host write visible to a read or FETCH at the following edge.
- ALU latency:
  - op_start sampled at edge E0;
  - busy=1 from E0 to E3;
  - reg[dst], flag and done updated at E3.
- done is high for exactly one cycle after E3. The earliest next op_start is sampled at E3+1.
- Back-to-back ops: throughput of one op per 4 cycles.

## Test plan
- Reset: drive rst=0 for 2 edges after arbitrary writes. Require data_out, flag, busy and done = 0, and a read of every address returns 0.
- ADD with overflow: R4=141, R5=208, ADD src_a=4 src_b=5 dst=2. Require busy for 3 cycles, a single done pulse at E3, R2=93, flag {V,N,Z,C}={1,0,0,1}.
- Carry chain:
  - R0=0xFF, R1=0x01, ADD to R2: require R2=0, flag={0,0,1,1}.
  - Then R6=R7=0, ADC to R3: require R3=1, flag={0,0,0,0}.
- SUB borrow: R8=32, R7=208, SUB src_a=8 src_b=7 dst=9. Require R9=80, flag={0,0,0,1}. Then AND R7,R7 to R10: require R10=208, flag={0,1,0,0}.
- Busy protection: start ADD into R2, then host-write 0x55 to R2 and pulse op_start during busy. Require R2 to hold the ADD result, exactly one done pulse, and no second operation.
- Reset mid-op: rst=0 during EXEC. Require IDLE, busy=0, no done pulse, all registers 0. Then a fresh op completes normally.
